// File: rtl/shift_pkg.sv
// Shared types and helpers for the universal shift engine: operation codes,
// FSM states and the effective-amount rule applied when a request is accepted.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_SHL  = 3'd0,
    OP_SHR  = 3'd1,
    OP_SAR  = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_SSL  = 3'd5,
    OP_SSR  = 3'd6,
    OP_LOAD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Rotating by a multiple of the width is a no-op, so rotates wrap; plain
  // shifts saturate at the width because every bit is gone by then.
  function automatic int unsigned eff_amount(input op_e         op,
                                             input int unsigned amount,
                                             input int unsigned width);
    int unsigned result;
    case (op)
      OP_ROL, OP_ROR: result = amount % width;
      OP_LOAD:        result = 0;
      default:        result = (amount > width) ? width : amount;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position step of the universal shifter: produces the
// next word and the bit that leaves the word for the given operation.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_word,
  input  op_e              i_op,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_next_word,
  output logic             o_out_bit
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_next_word = i_word;
    o_out_bit   = 1'b0;
    case (i_op)
      OP_SHL: begin
        o_next_word = {i_word[WIDTH-2:0], 1'b0};
        o_out_bit   = i_word[WIDTH-1];
      end
      OP_SHR: begin
        o_next_word = {1'b0, i_word[WIDTH-1:1]};
        o_out_bit   = i_word[0];
      end
      OP_SAR: begin
        o_next_word = {i_word[WIDTH-1], i_word[WIDTH-1:1]};
        o_out_bit   = i_word[0];
      end
      OP_ROL: begin
        o_next_word = {i_word[WIDTH-2:0], i_word[WIDTH-1]};
        o_out_bit   = i_word[WIDTH-1];
      end
      OP_ROR: begin
        o_next_word = {i_word[0], i_word[WIDTH-1:1]};
        o_out_bit   = i_word[0];
      end
      OP_SSL: begin
        o_next_word = {i_word[WIDTH-2:0], i_ser_in};
        o_out_bit   = i_word[WIDTH-1];
      end
      OP_SSR: begin
        o_next_word = {i_ser_in, i_word[WIDTH-1:1]};
        o_out_bit   = i_word[0];
      end
      default: begin
        o_next_word = i_word;
        o_out_bit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_engine.sv
// Multi-cycle universal shift/rotate engine: one bit position per clock for a
// run-time amount, with start/busy/done handshake and synchronous clear.
module univ_shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out
);

  localparam int unsigned WIDTH_U = WIDTH;

  state_e           r_state, w_state_nxt;
  op_e              r_op,    w_op_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_data,  w_data_nxt;
  logic             r_ser,   w_ser_nxt;

  logic [WIDTH-1:0] w_step_word;
  logic             w_step_bit;
  logic [CNT_W-1:0] w_eff;

  assign w_eff = CNT_W'(eff_amount(op_e'(op), 32'(amount), WIDTH_U));

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_word      (r_data),
    .i_op        (r_op),
    .i_ser_in    (ser_in),
    .o_next_word (w_step_word),
    .o_out_bit   (w_step_bit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_ser_nxt   = r_ser;
    if (clr) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_data_nxt  = '0;
      w_ser_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // A new request is taken from DONE too, giving back-to-back operation.
          if (start) begin
            w_data_nxt  = data_in;
            w_op_nxt    = op_e'(op);
            w_cnt_nxt   = w_eff;
            w_state_nxt = (w_eff != '0) ? SHIFT : DONE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        SHIFT: begin
          w_data_nxt = w_step_word;
          w_ser_nxt  = w_step_bit;
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_op    <= OP_SHL;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ser   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_ser   <= w_ser_nxt;
    end
  end

  assign busy     = (r_state == SHIFT);
  assign done     = (r_state == DONE);
  assign data_out = r_data;
  assign ser_out  = r_ser;

endmodule

// File: tb/tb_univ_shift_engine.sv
// Self-checking bench for univ_shift_engine: a reference model pushes expected
// results at each start, and a monitor pops and compares them on every done.
module tb_univ_shift_engine;
  import shift_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          clr     = 1'b0;
  logic          start   = 1'b0;
  logic [2:0]    op      = 3'd0;
  logic [CW-1:0] amount  = '0;
  logic [W-1:0]  data_in = '0;
  logic          ser_in  = 1'b0;
  logic          busy, done, ser_out;
  logic [W-1:0]  data_out;

  univ_shift_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .start    (start),
    .op       (op),
    .amount   (amount),
    .data_in  (data_in),
    .ser_in   (ser_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .ser_out  (ser_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         ser;
    int           n;
    int           s;
    int           id;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   busy_cnt  = 0;
  int   next_id   = 0;
  logic model_ser = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference behaviour, written straight from the operation definitions.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] d,
                                input int a, input logic sin, input logic ps,
                                output logic [W-1:0] r, output logic so,
                                output int n);
    r  = d;
    so = ps;
    if (o == 3'd3 || o == 3'd4) n = a % W;
    else if (o == 3'd7)         n = 0;
    else                        n = (a > W) ? W : a;
    for (int i = 0; i < n; i++) begin
      case (o)
        3'd0: begin so = r[W-1]; r = r << 1; end
        3'd1: begin so = r[0];   r = r >> 1; end
        3'd2: begin so = r[0];   r = {r[W-1], r[W-1:1]}; end
        3'd3: begin so = r[W-1]; r = (r << 1) | (r >> (W-1)); end
        3'd4: begin so = r[0];   r = (r >> 1) | (r << (W-1)); end
        3'd5: begin so = r[W-1]; r = (r << 1) | W'(sin); end
        3'd6: begin so = r[0];   r = {sin, r[W-1:1]}; end
        default: ;
      endcase
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_cnt++;
      if (done) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: done=1 with nothing pending at cycle %0d", cyc);
        end else begin
          e_mon = sb.pop_front();
          n_checks++;
          if (data_out !== e_mon.data) begin
            n_fail++;
            $display("FAIL op#%0d data_out: got %h expected %h", e_mon.id, data_out, e_mon.data);
          end
          n_checks++;
          if (ser_out !== e_mon.ser) begin
            n_fail++;
            $display("FAIL op#%0d ser_out: got %b expected %b", e_mon.id, ser_out, e_mon.ser);
          end
          n_checks++;
          if ((cyc - e_mon.s) != e_mon.n) begin
            n_fail++;
            $display("FAIL op#%0d latency: got %0d expected %0d", e_mon.id, cyc - e_mon.s, e_mon.n);
          end
          n_checks++;
          if (busy_cnt != e_mon.n) begin
            n_fail++;
            $display("FAIL op#%0d busy_cycles: got %0d expected %0d", e_mon.id, busy_cnt, e_mon.n);
          end
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic drive_start(input logic [2:0] o, input logic [W-1:0] d,
                             input logic [CW-1:0] a, input logic sin);
    logic [W-1:0] r;
    logic         so;
    int           n;
    exp_t         x;
    op      = o;
    data_in = d;
    amount  = a;
    ser_in  = sin;
    start   = 1'b1;
    model(o, d, int'(a), sin, model_ser, r, so, n);
    x.data = r; x.ser = so; x.n = n; x.s = cyc + 1; x.id = next_id;
    next_id++;
    sb.push_back(x);
    model_ser = so;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] d,
                       input logic [CW-1:0] a, input logic sin);
    @(negedge clk);
    drive_start(o, d, a, sin);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain_timeout: %0d results still pending, expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== '0 || ser_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s outputs: got busy=%b done=%b data_out=%h ser_out=%b expected all 0",
               name, busy, done, data_out, ser_out);
    end
  endtask

  task automatic test_reset;
    #1;
    check_idle("reset_asserted");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_released");
  endtask

  task automatic test_shl;
    issue(OP_SHL, 8'hB1, 4'd3, 1'b0);
    wait_drain("shl");
  endtask

  task automatic test_rotate_sar;
    issue(OP_ROR, 8'hA5, 4'd12, 1'b0);
    wait_drain("ror_wrap");
    issue(OP_SAR, 8'h90, 4'd2, 1'b0);
    wait_drain("sar");
    issue(OP_ROL, 8'h96, 4'd8, 1'b0);
    wait_drain("rol_full_turn");
  endtask

  task automatic test_serial_clamp;
    issue(OP_SSR, 8'h00, 4'd3, 1'b1);
    wait_drain("ssr");
    issue(OP_SHL, 8'hFF, 4'd9, 1'b0);
    wait_drain("shl_clamp");
    issue(OP_SHR, 8'hC3, 4'd15, 1'b0);
    wait_drain("shr_clamp");
  endtask

  task automatic test_zero_load;
    issue(OP_SHR, 8'h5A, 4'd0, 1'b0);
    wait_drain("amount_zero");
    issue(OP_LOAD, 8'h3C, 4'd7, 1'b1);
    wait_drain("load");
  endtask

  task automatic test_back_to_back;
    issue(OP_SHL, 8'hB1, 4'd3, 1'b0);
    // A second request while busy, with different operands, must be ignored.
    op      = OP_SAR;
    data_in = 8'hFF;
    amount  = 4'd2;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b done_wait: got done=%b expected 1", done);
    end
    drive_start(OP_ROL, 8'h81, 4'd1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_drain("back_to_back");
  endtask

  task automatic test_rst_mid;
    issue(OP_SHL, 8'hFF, 4'd6, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_idle("async_reset_mid_shift");
    sb.delete();
    busy_cnt  = 0;
    model_ser = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("after_mid_reset");
  endtask

  task automatic test_clr_mid;
    issue(OP_SHL, 8'hFF, 4'd5, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    sb.delete();
    @(negedge clk);
    check_idle("clr_mid_shift");
    clr       = 1'b0;
    model_ser = 1'b0;
    busy_cnt  = 0;
    @(negedge clk);
    check_idle("clr_idle_1");
    @(negedge clk);
    check_idle("clr_idle_2");
    issue(OP_SSL, 8'h01, 4'd2, 1'b1);
    wait_drain("after_clr");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_shl();
    test_rotate_sar();
    test_serial_clamp();
    test_zero_load();
    test_back_to_back();
    test_rst_mid();
    test_clr_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
